input_frontend: RTL and testbench

Parametrised input conditioning front-end placed between the chip pins and the compute core. It generalises the per-pin synchronizer instances into one block with these functions:
- N-stage synchronization of a data bus and of several command (button) channels.
- Per-channel counter-based debounce on the command channels, with registered rise and fall pulses.
- A data capture register that latches the synchronized bus on a selected command's press and issues a one-cycle valid strobe.

---
 rtl/input_frontend_if.sv | 25 ++
 rtl/input_frontend.sv | 89 ++++++++
 tb/tb_input_frontend.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_frontend_if.sv
// Pin-side and core-side signals of the input front-end.
// The master modport drives the pins and observes the conditioned outputs.
interface input_frontend_if #(
    parameter int DATA_W = 6,
    parameter int CMD_W  = 2
);
    logic [DATA_W-1:0] data_pin;
    logic [CMD_W-1:0]  cmd_pin;
    logic [DATA_W-1:0] data_sync;
    logic [CMD_W-1:0]  cmd_level;
    logic [CMD_W-1:0]  cmd_rise;
    logic [CMD_W-1:0]  cmd_fall;
    logic [DATA_W-1:0] data_hold;
    logic              data_valid;

    modport master (
        output data_pin, cmd_pin,
        input  data_sync, cmd_level, cmd_rise, cmd_fall, data_hold, data_valid
    );

    modport slave (
        input  data_pin, cmd_pin,
        output data_sync, cmd_level, cmd_rise, cmd_fall, data_hold, data_valid
    );
endinterface

// File: rtl/input_frontend.sv
// Input conditioning: synchronizer chains, per-channel debounce with edge
// pulses, and a data capture register loaded on a selected button press.
module input_frontend #(
    parameter int DATA_W          = 6,
    parameter int CMD_W           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CAPTURE_CH      = 1
) (
    input logic               clock,
    input logic               reset_n,
    input_frontend_if.slave   fe
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][DATA_W-1:0] data_chain_q;
    logic [SYNC_STAGES-1:0][CMD_W-1:0]  cmd_chain_q;
    logic [DATA_W-1:0]                  data_sync;
    logic [CMD_W-1:0]                   cmd_sync;

    logic [CNT_W-1:0] cnt_q [CMD_W];
    logic [CNT_W-1:0] cnt_d [CMD_W];
    logic [CMD_W-1:0] level_q, level_d;
    logic [CMD_W-1:0] rise_q, rise_d;
    logic [CMD_W-1:0] fall_q, fall_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              valid_q, valid_d;

    assign data_sync = data_chain_q[SYNC_STAGES-1];
    assign cmd_sync  = cmd_chain_q[SYNC_STAGES-1];

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int ch = 0; ch < CMD_W; ch++) begin
            cnt_d[ch] = '0;
            if (cmd_sync[ch] != level_q[ch]) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    level_d[ch] = cmd_sync[ch];
                    rise_d[ch]  = cmd_sync[ch];
                    fall_d[ch]  = ~cmd_sync[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end
        end
        // Capture samples the bus value present at the accepting edge.
        valid_d = rise_d[CAPTURE_CH];
        hold_d  = valid_d ? data_sync : hold_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_chain_q <= '0;
            cmd_chain_q  <= '0;
            // NOTE: the counter array is small and its state is observable, so it is reset like any flop.
            for (int ch = 0; ch < CMD_W; ch++) begin
                cnt_q[ch] <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_chain_q <= {data_chain_q[SYNC_STAGES-2:0], fe.data_pin};
            cmd_chain_q  <= {cmd_chain_q[SYNC_STAGES-2:0], fe.cmd_pin};
            for (int ch = 0; ch < CMD_W; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign fe.data_sync  = data_sync;
    assign fe.cmd_level  = level_q;
    assign fe.cmd_rise   = rise_q;
    assign fe.cmd_fall   = fall_q;
    assign fe.data_hold  = hold_q;
    assign fe.data_valid = valid_q;
endmodule

// File: tb/tb_input_frontend.sv
// Bench for input_frontend: default instance checked every cycle against a
// sample-history model; a second instance covers the alternate parameter set.
module tb_input_frontend;
    localparam int DW = 6, CW = 2, S = 2, D = 4, CAP = 1;
    localparam int OW = 3 * CW + 2 * DW + 1;
    localparam int OW2 = 3 * 4 + 2 * 8 + 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    input_frontend_if #(.DATA_W(DW), .CMD_W(CW)) bus ();
    input_frontend_if #(.DATA_W(8),  .CMD_W(4))  bus2 ();

    input_frontend #(.DATA_W(DW), .CMD_W(CW), .SYNC_STAGES(S),
                     .DEBOUNCE_CYCLES(D), .CAPTURE_CH(CAP))
        dut (.clock(clock), .reset_n(reset_n), .fe(bus));

    input_frontend #(.DATA_W(8), .CMD_W(4), .SYNC_STAGES(3),
                     .DEBOUNCE_CYCLES(1), .CAPTURE_CH(3))
        dut2 (.clock(clock), .reset_n(reset_n), .fe(bus2));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: raw pin samples, newest first; a level is accepted once the
    // synchronized view has disagreed with it for D edges since its last change.
    logic [CW-1:0] cmd_hist[$];
    logic [DW-1:0] data_hist[$];
    int            since_flip[CW];
    logic [CW-1:0] m_level, m_rise, m_fall;
    logic [DW-1:0] m_sync, m_hold;
    logic          m_valid;

    task automatic model_reset();
        cmd_hist.delete();
        data_hist.delete();
        for (int ch = 0; ch < CW; ch++) since_flip[ch] = D;
        m_level = '0; m_rise = '0; m_fall = '0;
        m_sync  = '0; m_hold = '0; m_valid = 1'b0;
    endtask

    function automatic logic [CW-1:0] cmd_at(int i);
        return (i < cmd_hist.size()) ? cmd_hist[i] : '0;
    endfunction

    function automatic logic [DW-1:0] data_at(int i);
        return (i < data_hist.size()) ? data_hist[i] : '0;
    endfunction

    task automatic model_edge();
        logic accept;
        cmd_hist.push_front(bus.cmd_pin);
        data_hist.push_front(bus.data_pin);
        if (cmd_hist.size() > S + D) void'(cmd_hist.pop_back());
        if (data_hist.size() > S + 1) void'(data_hist.pop_back());
        m_rise = '0; m_fall = '0; m_valid = 1'b0;
        for (int ch = 0; ch < CW; ch++) begin
            if (since_flip[ch] < D) since_flip[ch]++;
            accept = (since_flip[ch] >= D);
            for (int j = 0; j < D; j++) begin
                if (cmd_at(S + j)[ch] == m_level[ch]) accept = 1'b0;
            end
            if (accept) begin
                m_level[ch]    = ~m_level[ch];
                m_rise[ch]     = m_level[ch];
                m_fall[ch]     = ~m_level[ch];
                since_flip[ch] = 0;
            end
        end
        if (m_rise[CAP]) begin
            m_hold  = data_at(S);
            m_valid = 1'b1;
        end
        m_sync = data_at(S - 1);
    endtask

    function automatic logic [OW-1:0] obs();
        return {bus.cmd_level, bus.cmd_rise, bus.cmd_fall,
                bus.data_sync, bus.data_hold, bus.data_valid};
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        return {m_level, m_rise, m_fall, m_sync, m_hold, m_valid};
    endfunction

    function automatic logic [OW2-1:0] obs2();
        return {bus2.cmd_level, bus2.cmd_rise, bus2.cmd_fall,
                bus2.data_sync, bus2.data_hold, bus2.data_valid};
    endfunction

    task automatic step();
        @(posedge clock);
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic idle(int n);
        bus.cmd_pin  = '0;
        bus2.cmd_pin = '0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            bus.data_pin  = DW'($urandom);
            bus.cmd_pin   = CW'($urandom);
            bus2.data_pin = 8'($urandom);
            bus2.cmd_pin  = 4'($urandom);
            step();
            n_checks++;
            if (obs() !== '0 || obs2() !== '0)
                $display("FAIL reset_hold cyc=%0d got=%h/%h want=0", i, obs(), obs2());
            else n_pass++;
        end
        bus.cmd_pin = '1; bus2.cmd_pin = '0; bus2.data_pin = '0;
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (obs() !== exp_vec())
                $display("FAIL reset_release cyc=%0d got=%h want=%h", i, obs(), exp_vec());
            else n_pass++;
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs() !== '0)
            $display("FAIL reset_async got=%h want=0", obs());
        else n_pass++;
        bus.cmd_pin = '0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_clean_press();
        int rises = 0, falls = 0, rise_at = -1, fall_at = -1;
        idle(12);
        bus.cmd_pin[1] = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            n_checks++;
            if (obs() !== exp_vec())
                $display("FAIL clean_model k=%0d got=%h want=%h", k, obs(), exp_vec());
            else n_pass++;
            if (bus.cmd_rise[1]) begin rises++; rise_at = k; end
            if (bus.cmd_fall[1]) begin falls++; fall_at = k; end
            if (k == 20) bus.cmd_pin[1] = 1'b0;
        end
        n_checks++;
        if (rises !== 1 || rise_at !== 6)
            $display("FAIL clean_rise count=%0d at=%0d want 1 at 6", rises, rise_at);
        else n_pass++;
        n_checks++;
        if (falls !== 1 || fall_at !== 26)
            $display("FAIL clean_fall count=%0d at=%0d want 1 at 26", falls, fall_at);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int rises = 0, falls = 0, rise_at = -1;
        logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        idle(12);
        for (int i = 0; i < 4; i++) begin
            bus.cmd_pin[0] = pat[i];
            step();
            if (bus.cmd_rise[0]) rises++;
            if (bus.cmd_fall[0]) falls++;
        end
        bus.cmd_pin[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_checks++;
            if (obs() !== exp_vec())
                $display("FAIL bounce_model k=%0d got=%h want=%h", k, obs(), exp_vec());
            else n_pass++;
            if (bus.cmd_rise[0]) begin rises++; rise_at = k; end
            if (bus.cmd_fall[0]) falls++;
        end
        n_checks++;
        if (rises !== 1 || rise_at !== 6 || falls !== 0)
            $display("FAIL bounce_rise rises=%0d at=%0d falls=%0d want 1 at 6, 0 falls",
                     rises, rise_at, falls);
        else n_pass++;
    endtask

    task automatic test_capture();
        int valids = 0;
        idle(2);
        bus.data_pin = 6'h2A;
        idle(12);
        bus.cmd_pin[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if (k == 6 && (bus.data_valid !== 1'b1 || bus.data_hold !== 6'h2A))
                $display("FAIL capture_load valid=%b hold=%h want 1/2a", bus.data_valid, bus.data_hold);
            else if (k != 6 && bus.data_valid !== 1'b0)
                $display("FAIL capture_strobe k=%0d valid=%b want 0", k, bus.data_valid);
            else n_pass++;
        end
        idle(12);
        bus.data_pin = 6'h15;
        step(); step(); step();
        bus.cmd_pin[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.data_valid) valids++;
            n_checks++;
            if (obs() !== exp_vec())
                $display("FAIL capture_model k=%0d got=%h want=%h", k, obs(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (valids !== 0 || bus.data_hold !== 6'h2A)
            $display("FAIL capture_other_ch valids=%0d hold=%h want 0/2a", valids, bus.data_hold);
        else n_pass++;
    endtask

    task automatic test_simultaneous_and_reset();
        int both_at = -1, rises = 0, rise_at = -1;
        idle(12);
        bus.cmd_pin = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (bus.cmd_rise == 2'b11) both_at = k;
        end
        n_checks++;
        if (both_at !== 6)
            $display("FAIL simul_rise at=%0d want 6", both_at);
        else n_pass++;
        idle(12);
        bus.cmd_pin[1] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (bus.cmd_rise[1]) rises++;
        end
        #1 reset_n = 1'b0;
        model_reset();
        #1 reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if (obs() !== exp_vec())
                $display("FAIL midreset_model k=%0d got=%h want=%h", k, obs(), exp_vec());
            else n_pass++;
            if (bus.cmd_rise[1]) begin rises++; rise_at = k; end
        end
        n_checks++;
        if (rises !== 1 || rise_at !== 6)
            $display("FAIL midreset_rise count=%0d at=%0d want 1 at 6", rises, rise_at);
        else n_pass++;
    endtask

    task automatic test_random();
        int hold_left[CW];
        idle(12);
        for (int ch = 0; ch < CW; ch++) hold_left[ch] = 1;
        for (int t = 0; t < 400; t++) begin
            for (int ch = 0; ch < CW; ch++) begin
                hold_left[ch]--;
                if (hold_left[ch] == 0) begin
                    bus.cmd_pin[ch] = ~bus.cmd_pin[ch];
                    hold_left[ch]   = int'($urandom_range(9, 1));
                end
            end
            if ($urandom_range(3, 0) == 0) bus.data_pin = DW'($urandom);
            step();
            n_checks++;
            if (obs() !== exp_vec())
                $display("FAIL random_model t=%0d got=%h want=%h", t, obs(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_param_sweep();
        int rise_at = -1;
        bus2.data_pin = 8'hA5;
        idle(8);
        bus2.cmd_pin[3] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (bus2.cmd_rise != 4'b0000) rise_at = k;
            if (k == 4) begin
                n_checks++;
                if (bus2.cmd_rise !== 4'b1000 || bus2.cmd_level !== 4'b1000 ||
                    bus2.data_valid !== 1'b1 || bus2.data_hold !== 8'hA5)
                    $display("FAIL sweep_capture rise=%b level=%b valid=%b hold=%h want 1000/1000/1/a5",
                             bus2.cmd_rise, bus2.cmd_level, bus2.data_valid, bus2.data_hold);
                else n_pass++;
            end
        end
        n_checks++;
        if (rise_at !== 4)
            $display("FAIL sweep_latency last_rise=%0d want 4", rise_at);
        else n_pass++;
    endtask

    initial begin
        bus.data_pin = '0; bus.cmd_pin = '0;
        bus2.data_pin = '0; bus2.cmd_pin = '0;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_capture();
        test_simultaneous_and_reset();
        test_random();
        test_param_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
